stopwatch_key_fsm: RTL
======================

# stopwatch_key_fsm

Front-end stage of the stop watch: turns raw KEY pushbuttons and the 50 MHz board clock into the control signals the counter/display controller consumes. It synchronises and debounces three keys, runs the RESET/COUNTING/PAUSE/DISPLAY_STOP mode machine, and issues a 10 ms count strobe. It sits directly upstream of the counter/display controller and drives the status LEDs.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 100: count strobe rate (10 ms period).
- DEBOUNCE_MS, 20: stable time required before a key level is accepted.
- clk  in  1  board clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; one clock domain only.
- key_reset_n  in  1  raw pushbutton, low = pressed, asynchronous.
- key_start_n  in  1  raw start/pause pushbutton, low = pressed.
- key_display_n  in  1  raw display-freeze pushbutton, low = pressed.
- count_step  out  1  one-cycle pulse, advance counter by one 10 ms unit.
- count_clear  out  1  high while the counter must be held at zero.
- display_en  out  1  high = display follows count; low = display frozen.
- led  out  4  one-hot mode: [0] reset/stop, [1] counting, [2] pause, [3] display_stop.

## Operation
- Each key: 2-flop synchroniser (reset to 1), then debouncer. Debounced level changes only after synchronised input holds the new value for DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS consecutive cycles; any mismatch restarts the count. Press event = one-cycle pulse on debounced 1->0 transition; release produces nothing. Holding a key never repeats.
- Divider: counts 0..DIV-1, DIV = CLK_HZ/TICK_HZ; terminal count wraps to 0. Held at 0 whenever state is RESET or PAUSE, so the first strobe after start is exactly DIV cycles later. count_step = 1 for the cycle the divider is at DIV-1 and state is COUNTING or DISPLAY_STOP.
- States and outputs (Moore): RESET: count_clear=1, display_en=1, led=0001. COUNTING: clear=0, display_en=1, led=0010. PAUSE: clear=0, display_en=1, led=0100. DISPLAY_STOP: clear=0, display_en=0, led=1000.
- Transitions on press pulses: RESET --start--> COUNTING. COUNTING --start--> PAUSE, --display--> DISPLAY_STOP. PAUSE --start--> COUNTING. DISPLAY_STOP --display--> COUNTING, --start--> PAUSE. reset key from any state -> RESET. All other press/state pairs ignored (display in PAUSE or RESET, start... none ignored beyond these).
- Simultaneous presses in one cycle: reset key > start > display; only the highest-priority press acts, others dropped.

## Timing
- Async reset: state=RESET, divider=0, debounced levels=1, count_step=0, count_clear=1, display_en=1, led=0001; takes effect immediately, mid-debounce or mid-count.
- Key latency: raw edge -> 2 sync cycles -> DB_CYCLES -> press pulse -> state/outputs change on the next edge (total DB_CYCLES+3 cycles, ±1 for sampling).
- All outputs registered or decoded from registered state; no combinational path from key pins.
- Entering PAUSE or RESET on the same cycle the divider hits DIV-1: no strobe issued.
- Bounce shorter than DB_CYCLES produces no event.

## Structure
- Package stopwatch_pkg: state enum (RESET, COUNTING, PAUSE, DISPLAY_STOP), LED one-hot constants, default CLK_HZ/TICK_HZ/DEBOUNCE_MS.
- Sub-module key_debounce (synchroniser + stability counter + press pulse), instantiated three times; parameter DB_CYCLES.

## Test plan
Use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_MS=4 (DB_CYCLES=4).
- Reset released, no keys -> led=0001, count_clear=1, count_step never high for 100 cycles.
- Clean start press held 10 cycles -> led=0010 within 7 cycles; count_step pulses every 10 cycles, first exactly 10 cycles after entry.
- Start key bouncing (toggling every 2 cycles for 12 cycles, then low) -> exactly one transition to COUNTING; second clean start -> PAUSE, count_step stops, led=0100.
- In COUNTING press display -> display_en=0, led=1000, count_step continues every 10; press display again -> display_en=1, led=0010.
- Start and reset pressed on the same cycle while COUNTING -> RESET, count_clear=1, led=0001, divider 0.
- Assert reset mid-debounce and mid-divider -> outputs at reset values same cycle; after release, partial key press requires a full 4 stable cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and constants for the stopwatch key front end.
//   - sw_state_e : mode machine states
//   - LED_*      : one-hot status LED patterns, one per state
//   - DEF_*      : default clock / strobe / debounce settings for the board
//   - is_running : true in the states where the 10 ms divider runs
package stopwatch_pkg;

  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_TICK_HZ     = 100;
  localparam int unsigned DEF_DEBOUNCE_MS = 20;

  typedef enum logic [1:0] {
    ST_RESET        = 2'd0,
    ST_COUNTING     = 2'd1,
    ST_PAUSE        = 2'd2,
    ST_DISPLAY_STOP = 2'd3
  } sw_state_e;

  localparam logic [3:0] LED_RESET        = 4'b0001;
  localparam logic [3:0] LED_COUNTING     = 4'b0010;
  localparam logic [3:0] LED_PAUSE        = 4'b0100;
  localparam logic [3:0] LED_DISPLAY_STOP = 4'b1000;

  function automatic logic is_running(input sw_state_e s);
    return (s == ST_COUNTING) || (s == ST_DISPLAY_STOP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Synchronises one raw active-low pushbutton, debounces it and emits a
//   single-cycle pulse when the debounced level goes from released (1) to
//   pressed (0). Releases and long holds produce nothing.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset
//   key_n_i  in   raw pushbutton, low = pressed, asynchronous to clk
//   press_o  out  registered one-cycle press pulse
module key_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // cnt_q counts consecutive cycles in which the synchronised key disagrees
  // with the accepted level; the level flips on the DB_CYCLES-th such cycle.
  // Any cycle of agreement drops the count back to zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_q & ~level_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_key_fsm.sv
// stopwatch_key_fsm
//   Front end of the stopwatch: debounces the three keys, runs the mode
//   machine and produces the 10 ms count strobe for the counter/display
//   controller.
// Ports:
//   clk            in   board clock
//   reset          in   asynchronous active-high reset
//   key_reset_n    in   raw reset pushbutton, low = pressed
//   key_start_n    in   raw start/pause pushbutton, low = pressed
//   key_display_n  in   raw display-freeze pushbutton, low = pressed
//   count_step     out  one-cycle strobe, advance counter by one 10 ms unit
//   count_clear    out  hold counter at zero
//   display_en     out  1 = display follows count, 0 = display frozen
//   led            out  one-hot mode indication
//
// state           | meaning
// ----------------+-----------------------------------------------
// ST_RESET        | counter held at zero, divider idle
// ST_COUNTING     | divider running, display follows count
// ST_PAUSE        | divider held at zero, count frozen and shown
// ST_DISPLAY_STOP | divider running, display frozen
module stopwatch_key_fsm
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned TICK_HZ     = DEF_TICK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_reset_n,
  input  logic       key_start_n,
  input  logic       key_display_n,
  output logic       count_step,
  output logic       count_clear,
  output logic       display_en,
  output logic [3:0] led
);

  localparam int unsigned DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic press_rst, press_start, press_disp;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_reset_n),
    .press_o (press_rst)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_start_n),
    .press_o (press_start)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_display (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_display_n),
    .press_o (press_disp)
  );

  sw_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          step_q, step_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the highest-priority press in a cycle acts: reset, start, display.
  always_comb begin
    state_d = state_q;
    if (press_rst) begin
      state_d = ST_RESET;
    end else if (press_start) begin
      case (state_q)
        ST_RESET:        state_d = ST_COUNTING;
        ST_COUNTING:     state_d = ST_PAUSE;
        ST_PAUSE:        state_d = ST_COUNTING;
        ST_DISPLAY_STOP: state_d = ST_PAUSE;
        default:         state_d = ST_RESET;
      endcase
    end else if (press_disp) begin
      case (state_q)
        ST_COUNTING:     state_d = ST_DISPLAY_STOP;
        ST_DISPLAY_STOP: state_d = ST_COUNTING;
        default:         state_d = state_q;
      endcase
    end
  end

  always_comb begin
    led         = LED_RESET;
    count_clear = 1'b1;
    display_en  = 1'b1;
    case (state_q)
      ST_COUNTING: begin
        led         = LED_COUNTING;
        count_clear = 1'b0;
      end
      ST_PAUSE: begin
        led         = LED_PAUSE;
        count_clear = 1'b0;
      end
      ST_DISPLAY_STOP: begin
        led         = LED_DISPLAY_STOP;
        count_clear = 1'b0;
        display_en  = 1'b0;
      end
      default: begin
        led         = LED_RESET;
        count_clear = 1'b1;
        display_en  = 1'b1;
      end
    endcase
  end

  // The divider is forced to zero while idle and on the edge that leaves a
  // running state, so a fresh start always waits a full DIV cycles. The
  // strobe is suppressed on the edge that stops counting, even if the
  // divider is at its terminal count.
  always_comb begin
    if (!is_running(state_q) || !is_running(state_d)) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    step_d = is_running(state_q) && is_running(state_d) && (div_q == DIV_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
    end
  end

  assign count_step = step_q;

endmodule
